// File: rtl/freqdiv_pkg.sv
// rtl/freqdiv_pkg.sv - shared constants and helpers for the freqdiv_bank clock divider
package freqdiv_pkg;

  localparam int CNT_W_DEF  = 25;
  localparam int SYS_CLK_HZ = 40_000_000;

  // Half-periods in system clock cycles
  localparam int HALF_500HZ = 40_000;
  localparam int HALF_1HZ   = 20_000_000;
  localparam int HALF_2HZ   = 10_000_000;

  // Channel-select width, never narrower than one bit
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freqdiv_chan.sv
// rtl/freqdiv_chan.sv - one divider channel: half-period counter, square output, rise tick
// and a single-entry pending half-period applied at the end of a full period.
module freqdiv_chan import freqdiv_pkg::*; #(
  parameter int               CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_500HZ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_half,
  output logic             out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pend_half;
  logic             wrap;

  assign wrap = (cnt == half - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      out       <= 1'b0;
      tick      <= 1'b0;
      half      <= HALF_INIT;
      pend_half <= '0;
      pend      <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (sync) begin
        cnt <= '0;
        out <= 1'b0;
        if (pend) begin
          half <= pend_half;
          pend <= 1'b0;
        end
      end else if (half == '0) begin
        // Disabled channel: a pending value takes effect on the next enabled edge
        cnt <= '0;
        out <= 1'b0;
        if (pend && en) begin
          half <= pend_half;
          pend <= 1'b0;
        end
      end else if (en) begin
        if (wrap) begin
          cnt  <= '0;
          out  <= ~out;
          tick <= ~out;
          if (out && pend) begin
            half <= pend_half;
            pend <= 1'b0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A write is only accepted while pend is clear, so it never collides with an apply
      if (wr) begin
        pend_half <= wr_half;
        pend      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/freqdiv_bank.sv
// rtl/freqdiv_bank.sv - NUM_CH runtime-programmable clock divider bank with cfg write port.
// Define FREQDIV_SYNC_EN to add the sync input that phase-aligns all channels.
module freqdiv_bank import freqdiv_pkg::*; #(
  parameter int                      NUM_CH   = 3,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(HALF_2HZ), CNT_W'(HALF_1HZ),
                                                 CNT_W'(HALF_500HZ)}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_en,
`ifdef FREQDIV_SYNC_EN
  input  logic                        sync,
`endif
  input  logic                        cfg_valid,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]            cfg_half,
  output logic                        cfg_ready,
  output logic [NUM_CH-1:0]           div_out,
  output logic [NUM_CH-1:0]           div_tick
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  logic                   sync_all;
  logic [NUM_CH-1:0]      pend;
  logic [NUM_CH-1:0]      wr;
  logic [(1<<CH_W)-1:0]   ready_vec;

`ifdef FREQDIV_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  // Unused channel indices read as ready so writes to them are silently dropped
  always_comb begin
    ready_vec             = '1;
    ready_vec[NUM_CH-1:0] = ~pend;
  end

  assign cfg_ready = ready_vec[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    freqdiv_chan #(
      .CNT_W     (CNT_W),
      .HALF_INIT (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .en      (ch_en[i]),
      .sync    (sync_all),
      .wr      (wr[i]),
      .wr_half (cfg_half),
      .out     (div_out[i]),
      .tick    (div_tick[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_freqdiv_bank.sv
// tb/tb_freqdiv_bank.sv - self-checking bench for freqdiv_bank with a phase-based reference model
module tb_freqdiv_bank;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd3, 8'd2, 8'd1};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              cfg_valid = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic              sync_v = 1'b0;
  logic              cfg_ready;
  logic [NUM_CH-1:0] div_out;
  logic [NUM_CH-1:0] div_tick;

  always #5 clk = ~clk;

  freqdiv_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_en     (ch_en),
`ifdef FREQDIV_SYNC_EN
    .sync      (sync_v),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .div_out   (div_out),
    .div_tick  (div_tick)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each channel tracks its phase within a 2H-cycle period
  int              m_h[NUM_CH];
  int              m_ph[NUM_CH];
  bit              m_pend[NUM_CH];
  int              m_pend_half[NUM_CH];
  bit [NUM_CH-1:0] m_tick;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_h[i]         = int'(DIV_INIT[i*CNT_W +: CNT_W]);
      m_ph[i]        = 0;
      m_pend[i]      = 1'b0;
      m_pend_half[i] = 0;
    end
    m_tick = '0;
  endfunction

  function automatic bit m_ready();
    if (int'(cfg_ch) >= NUM_CH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  function automatic bit [NUM_CH-1:0] m_out_vec();
    bit [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = (m_h[i] != 0) && (m_ph[i] >= m_h[i]);
    return v;
  endfunction

  function automatic void apply(input int i);
    m_h[i]    = m_pend_half[i];
    m_pend[i] = 1'b0;
    m_ph[i]   = 0;
  endfunction

  function automatic void model_step();
    bit acc;
    acc = cfg_valid && m_ready() && (int'(cfg_ch) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 1'b0;
      if (sync_v) begin
        m_ph[i] = 0;
        if (m_pend[i]) apply(i);
      end else if (m_h[i] == 0) begin
        m_ph[i] = 0;
        if (m_pend[i] && ch_en[i]) apply(i);
      end else if (ch_en[i]) begin
        m_ph[i] = (m_ph[i] + 1) % (2 * m_h[i]);
        if (m_ph[i] == m_h[i]) m_tick[i] = 1'b1;
        else if (m_ph[i] == 0 && m_pend[i]) apply(i);
      end
    end
    if (acc) begin
      m_pend[cfg_ch]      = 1'b1;
      m_pend_half[cfg_ch] = int'(cfg_half);
    end
  endfunction

  // One clock: check ready before the edge, advance model, compare outputs after the edge
  task automatic step();
    #1 check("cfg_ready", int'(cfg_ready), int'(m_ready()));
    @(posedge clk);
    model_step();
    #1;
    check("div_out", int'(div_out), int'(m_out_vec()));
    check("div_tick", int'(div_tick), int'(m_tick));
  endtask

  task automatic count_until_rise(input int ch, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(div_out[ch] && div_tick[ch]) && n < max);
  endtask

  typedef struct {
    logic [2:0] en;
    logic [2:0] exp_out;
    logic [2:0] exp_tick;
  } vec_t;

  vec_t tv[12];

  task automatic run_table(input string tag);
    for (int k = 0; k < 12; k++) begin
      ch_en = tv[k].en;
      step();
      check({tag, "_out"}, int'(div_out), int'(tv[k].exp_out));
      check({tag, "_tick"}, int'(div_tick), int'(tv[k].exp_tick));
    end
  endtask

  initial begin
    int n, r0, r1;
    bit acc;

    // After reset with H={3,2,1}: ch0 period 2, ch1 period 4, ch2 period 6
    tv[0]  = '{3'b111, 3'b001, 3'b001};
    tv[1]  = '{3'b111, 3'b010, 3'b010};
    tv[2]  = '{3'b111, 3'b111, 3'b101};
    tv[3]  = '{3'b111, 3'b100, 3'b000};
    tv[4]  = '{3'b111, 3'b101, 3'b001};
    tv[5]  = '{3'b111, 3'b010, 3'b010};
    tv[6]  = '{3'b111, 3'b011, 3'b001};
    tv[7]  = '{3'b111, 3'b000, 3'b000};
    tv[8]  = '{3'b111, 3'b101, 3'b101};
    tv[9]  = '{3'b111, 3'b110, 3'b010};
    tv[10] = '{3'b111, 3'b111, 3'b001};
    tv[11] = '{3'b111, 3'b000, 3'b000};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", int'(div_out), 0);
    check("rst_tick", int'(div_tick), 0);
    check("rst_ready", int'(cfg_ready), 1);
    reset = 1'b1;
    ch_en = 3'b111;
    run_table("tbl");

    // Reprogram ch1 (H=2) to H=5 during its high phase
    step();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_half = 8'd5;
    step();
    cfg_half = 8'd7;
    check("ready_pending", int'(cfg_ready), 0);
    step();
    cfg_valid = 1'b0;
    check("ready_applied", int'(cfg_ready), 1);
    count_until_rise(1, 30, n);
    check("ch1_first_rise", n, 5);
    count_until_rise(1, 30, n);
    check("ch1_period", n, 10);

    // Write to a nonexistent channel is dropped with ready high
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_half = 8'd9;
    #1 check("ready_illegal", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    repeat (3) step();

    // Freeze ch0 for 7 cycles, then resume
    ch_en = 3'b110;
    repeat (7) begin
      step();
      check("frozen_tick", int'(div_tick[0]), 0);
    end
    ch_en = 3'b111;
    repeat (4) step();

    // H=0 disables ch0; H=4 re-enables it on the next edge
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd0;
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    check("disabled_out", int'(div_out[0]), 0);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd4;
    step();
    cfg_valid = 1'b0;
    step();
    check("ready_after_h0_apply", int'(cfg_ready), 1);
    count_until_rise(0, 30, n);
    check("ch0_rise_after_enable", n, 4);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      ch_en     = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_half  = 8'($urandom_range(0, 6));
`ifdef FREQDIV_SYNC_EN
      sync_v    = ($urandom_range(0, 30) == 0);
`endif
      step();
    end
    sync_v = 1'b0; cfg_valid = 1'b0; ch_en = 3'b111;
    repeat (2) step();

    // Async reset with a write pending on ch2
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_half = 8'd6;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      #1 acc = m_ready();
      step();
    end
    cfg_valid = 1'b0;
    check("pend_write_accepted", int'(acc), 1);
    check("ready_before_reset", int'(cfg_ready), 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_out", int'(div_out), 0);
    check("midrst_tick", int'(div_tick), 0);
    check("midrst_ready", int'(cfg_ready), 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_table("tbl2");

`ifdef FREQDIV_SYNC_EN
    // Sync aligns ch0 (H=3) and ch1 (H=5)
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd3;
    step();
    cfg_ch = 2'd1; cfg_half = 8'd5;
    step();
    cfg_valid = 1'b0;
    repeat (15) step();
    sync_v = 1'b1;
    step();
    sync_v = 1'b0;
    check("sync_out", int'(div_out[1:0]), 0);
    r0 = 0; r1 = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (r0 == 0 && div_tick[0]) r0 = i;
      if (r1 == 0 && div_tick[1]) r1 = i;
    end
    check("sync_rise_ch0", r0, 3);
    check("sync_rise_ch1", r1, 5);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/freqdiv_bank.md
# freqdiv_bank

Multi-channel, runtime-programmable clock divider that generates NUM_CH square-wave enables plus single-cycle tick strobes from the 40 MHz system clock. It is the parametrised successor of the fixed 500 Hz/1 Hz/2 Hz divider. Each channel's half-period is reprogrammable through a valid/ready write port, and updates are applied glitch-free at period boundaries. It feeds the display-multiplex, blink and seconds-timer logic of the parking controller.

## Interface
- NUM_CH, 3, number of divider channels (1..16)
- CNT_W, 25, half-period counter width
- DIV_INIT, {25'd10_000_000, 25'd20_000_000, 25'd40_000}, packed NUM_CH*CNT_W reset half-periods; ch0 in LSBs (defaults: ch0 500 Hz, ch1 1 Hz, ch2 2 Hz at 40 MHz)
- clk  in  1  system clock, 40 MHz
- reset  in  1  asynchronous, active-low reset
- ch_en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  write request
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_half  in  CNT_W  new half-period H
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- div_out  out  NUM_CH  square outputs, period 2H cycles, 50 % duty
- div_tick  out  NUM_CH  one-cycle strobe on each div_out rising edge

## Operation
- Per channel: registers cnt, out, half, pend_half, pend.
- Running (ch_en=1, half≠0):
  - cnt increments each cycle.
  - When cnt==half-1: cnt←0, out toggles. If out rises, tick←1 that cycle; otherwise tick←0.
- ch_en=0: cnt and out hold, tick=0. Resuming continues from the held state.
- half==0: channel disabled. cnt←0, out←0, tick=0.
- cfg_ready = ~pend[cfg_ch]. If cfg_ch ≥ NUM_CH, cfg_ready=1 and the write is dropped.
- Accepted write: pend_half←cfg_half, pend←1.
- Apply point:
  - The edge where out falls (end of a full period), or the next edge if half==0.
  - At that edge: half←pend_half, pend←0, cnt←0.
- A write accepted on the same edge as a falling-out event is applied at the next falling-out event, not the current one.
- A write of 0 disables the channel at its next apply point.
- ch_en=0 blocks the apply point; the write stays pending.

## Timing
- All outputs are registered.
- Reset values: div_out=0, div_tick=0, cnt=0, pend=0, half=DIV_INIT. cfg_ready=1 out of reset.
- After reset release with H≥1, the first div_out rise occurs on the H-th rising clk edge. div_tick is high for exactly that cycle.
- H=1: div_out toggles every cycle and div_tick fires every 2 cycles.
- cfg_ready drops the cycle after acceptance and returns high the cycle after apply.
- Reset asserted mid-operation clears everything immediately, including pending writes.

## Configuration
- FREQDIV_SYNC_EN defined:
  - Adds input port sync (1 bit).
  - sync=1 for one cycle, on that edge, for all channels:
    - cnt←0, out←0, tick←0;
    - pending values are applied, pend←0.
  - Channels are phase-aligned from the next cycle. sync has priority over cfg writes in the same cycle; the write is accepted and becomes pending.
- Not defined: no sync port; behaviour is identical to sync tied 0.

## Structure
- Package freqdiv_pkg:
  - CNT_W default;
  - 40 MHz clock constant;
  - half-period constants HALF_500HZ=40_000, HALF_1HZ=20_000_000, HALF_2HZ=10_000_000;
  - channel-index width helper.
- Sub-module freqdiv_chan: one channel (cnt, out, tick, half, pending logic). It is instantiated NUM_CH times in a generate loop.
- The top holds cfg decode, cfg_ready mux and sync fan-out.

## Test plan
- Reset/defaults: NUM_CH=3, DIV_INIT={3,2,1}, release reset → ch0 toggles every cycle, ch1 period 4, ch2 period 6; ticks on each rise; all zero during reset.
- Reprogram: ch1 H=2, write H=5 mid-high-phase → current period finishes at 4, then period 10; cfg_ready low from acceptance to apply.
- Backpressure/illegal: second write to ch1 while pending → held, cfg_ready=0. Write with cfg_ch=3 → ready=1, no channel changes.
- Enable/disable: ch_en[0]=0 for 7 cycles → out frozen, no ticks, resumes from held cnt. Write H=0 → out=0 after apply. Write H=4 → first rise 4 cycles after apply.
- Async reset mid-period plus pending write → outputs 0 immediately; half returns to DIV_INIT, pend cleared.
- FREQDIV_SYNC_EN: channels with H=3 and 5 out of phase, pulse sync → both outs 0 next cycle, rises at +3 and +5 cycles; without the macro, the build has no sync port.
